// File: rtl/rmw_pkg.sv
// Shared types and constants for the masked read-modify-write responder.
package rmw_pkg;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam logic [7:0] MASK_INIT = 8'h01;

    typedef enum logic [1:0] {
        OP_SET    = 2'b00,
        OP_CLR    = 2'b01,
        OP_TOGGLE = 2'b10,
        OP_LOAD   = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_READ   = 2'b01,
        ST_MODIFY = 2'b10,
        ST_WRITE  = 2'b11
    } state_t;

endpackage

// File: rtl/rmw_mask_reg.sv
// Rotating mask register: reinitialise on rst_mask, rotate left on shift.
module rmw_mask_reg
    import rmw_pkg::*;
#(
    parameter int WIDTH = rmw_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rst_mask,
    input  logic             shift,
    output logic [WIDTH-1:0] mask
);

    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] mask_d;

    // rst_mask wins over a coincident shift
    always_comb begin
        mask_d = mask_q;
        if (rst_mask) begin
            mask_d = WIDTH'(MASK_INIT);
        end else if (shift) begin
            mask_d = {mask_q[WIDTH-2:0], mask_q[WIDTH-1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mask_q <= WIDTH'(MASK_INIT);
        end else begin
            mask_q <= mask_d;
        end
    end

    assign mask = mask_q;

endmodule

// File: rtl/mask_rmw_responder.sv
// Masked RMW engine over a small register-array memory, with an independent read port.
// state  | meaning
// IDLE   | waiting for wr; captures op/addr/wdata/mask
// READ   | tmp <= mem[addr]
// MODIFY | tmp <= f(op, tmp, captured mask, wdata)
// WRITE  | mem[addr] <= tmp, done next cycle
module mask_rmw_responder
    import rmw_pkg::*;
#(
    parameter int WIDTH = rmw_pkg::WIDTH,
    parameter int DEPTH = rmw_pkg::DEPTH,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rst_mask,
    input  logic             shift,
    input  logic             wr,
    input  logic [1:0]       op,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic [WIDTH-1:0] mask,
    output logic             busy,
    output logic             done,
    output logic             err
);

    state_t           state_q;
    op_t              op_q;
    logic [AW-1:0]    addr_q;
    logic [WIDTH-1:0] wdata_q;
    logic [WIDTH-1:0] mcap_q;
    logic [WIDTH-1:0] tmp_q;
    logic [WIDTH-1:0] tmp_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;
    logic             rd_valid_q;
    logic             done_q;
    logic             err_q;

    rmw_mask_reg #(.WIDTH(WIDTH)) u_mask (
        .clk      (clk),
        .rst      (rst),
        .rst_mask (rst_mask),
        .shift    (shift),
        .mask     (mask)
    );

    always_comb begin
        tmp_d = tmp_q;
        case (op_q)
            OP_SET:    tmp_d = tmp_q | mcap_q;
            OP_CLR:    tmp_d = tmp_q & ~mcap_q;
            OP_TOGGLE: tmp_d = tmp_q ^ mcap_q;
            OP_LOAD:   tmp_d = (wdata_q & mcap_q) | (tmp_q & ~mcap_q);
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_SET;
            addr_q     <= '0;
            wdata_q    <= '0;
            mcap_q     <= '0;
            tmp_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rd_valid_q <= rd_en;
            // reads see mem_q before any same-edge WRITE update
            if (rd_en) begin
                rd_data_q <= mem_q[rd_addr];
            end
            case (state_q)
                ST_IDLE: begin
                    if (wr) begin
                        op_q    <= op_t'(op);
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        mcap_q  <= mask;
                        state_q <= ST_READ;
                    end
                end
                ST_READ: begin
                    err_q   <= wr;
                    tmp_q   <= mem_q[addr_q];
                    state_q <= ST_MODIFY;
                end
                ST_MODIFY: begin
                    err_q   <= wr;
                    tmp_q   <= tmp_d;
                    state_q <= ST_WRITE;
                end
                ST_WRITE: begin
                    err_q         <= wr;
                    mem_q[addr_q] <= tmp_q;
                    done_q        <= 1'b1;
                    state_q       <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign err      = err_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_mask_rmw_responder.sv
// Directed bench for mask_rmw_responder with hand-computed expected values.
module tb_mask_rmw_responder;
    import rmw_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rst_mask = 1'b0;
    logic       shift = 1'b0;
    logic       wr = 1'b0;
    logic [1:0] op = 2'b00;
    logic [2:0] addr = 3'd0;
    logic [7:0] wdata = 8'h00;
    logic       rd_en = 1'b0;
    logic [2:0] rd_addr = 3'd0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [7:0] mask;
    logic       busy;
    logic       done;
    logic       err;

    int checks = 0;
    int failures = 0;

    mask_rmw_responder dut (
        .clk      (clk),
        .rst      (rst),
        .rst_mask (rst_mask),
        .shift    (shift),
        .wr       (wr),
        .op       (op),
        .addr     (addr),
        .wdata    (wdata),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .mask     (mask),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_mask(input int k);
        rst_mask = 1'b1;
        step();
        rst_mask = 1'b0;
        repeat (k) begin
            shift = 1'b1;
            step();
        end
        shift = 1'b0;
    endtask

    task automatic do_rmw(input string tag, input logic [1:0] o, input logic [2:0] a, input logic [7:0] wd);
        wr = 1'b1; op = o; addr = a; wdata = wd;
        step();
        wr = 1'b0;
        check_eq({tag, "_busy1"}, busy, 1);
        step();
        check_eq({tag, "_busy2"}, busy, 1);
        step();
        check_eq({tag, "_busy3"}, busy, 1);
        check_eq({tag, "_nodone"}, done, 0);
        step();
        check_eq({tag, "_done"}, done, 1);
        check_eq({tag, "_idle"}, busy, 0);
        step();
        check_eq({tag, "_done_off"}, done, 0);
    endtask

    task automatic read_word(input string tag, input logic [2:0] a, input logic [7:0] exp);
        rd_en = 1'b1; rd_addr = a;
        step();
        rd_en = 1'b0;
        check_eq({tag, "_vld"}, rd_valid, 1);
        check_eq(tag, rd_data, exp);
    endtask

    initial begin
        // reset, with a wr driven that must be ignored
        wr = 1'b1; op = OP_SET; addr = 3'd0;
        step();
        step();
        wr = 1'b0;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_mask", mask, 8'h01);
        check_eq("rst_done", done, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_rdv", rd_valid, 0);
        check_eq("rst_rdd", rd_data, 8'h00);
        rst = 1'b1;
        step();
        check_eq("post_rst_busy", busy, 0);

        // mask rotation
        repeat (3) begin shift = 1'b1; step(); end
        shift = 1'b0;
        check_eq("mask_shift3", mask, 8'h08);
        rst_mask = 1'b1; shift = 1'b1;
        step();
        rst_mask = 1'b0; shift = 1'b0;
        check_eq("mask_prio", mask, 8'h01);
        set_mask(7);
        check_eq("mask_80", mask, 8'h80);
        shift = 1'b1; step(); shift = 1'b0;
        check_eq("mask_wrap", mask, 8'h01);

        // SET on mem[2] with mask 04
        set_mask(2);
        do_rmw("set2", OP_SET, 3'd2, 8'h00);
        read_word("rd2", 3'd2, 8'h04);
        step();
        check_eq("rdv_pulse", rd_valid, 0);
        check_eq("rd_hold", rd_data, 8'h04);

        // build mem[5]=FF, then CLR/TOGGLE
        for (int i = 0; i < 8; i++) begin
            set_mask(i);
            do_rmw("fill5", OP_SET, 3'd5, 8'h00);
        end
        read_word("rd5_ff", 3'd5, 8'hFF);
        set_mask(7);
        do_rmw("clr5a", OP_CLR, 3'd5, 8'h00);
        read_word("rd5_7f", 3'd5, 8'h7F);
        set_mask(0);
        do_rmw("clr5b", OP_CLR, 3'd5, 8'h00);
        read_word("rd5_7e", 3'd5, 8'h7E);
        do_rmw("tog5a", OP_TOGGLE, 3'd5, 8'h00);
        read_word("rd5_7f2", 3'd5, 8'h7F);
        set_mask(7);
        do_rmw("tog5b", OP_TOGGLE, 3'd5, 8'h00);
        read_word("rd5_ff2", 3'd5, 8'hFF);

        // mem[1]=F0, then LOAD A5 under masks 01, 02, 04
        for (int i = 4; i < 8; i++) begin
            set_mask(i);
            do_rmw("fill1", OP_SET, 3'd1, 8'h00);
        end
        read_word("rd1_f0", 3'd1, 8'hF0);
        set_mask(0);
        do_rmw("load1a", OP_LOAD, 3'd1, 8'hA5);
        read_word("rd1_f1", 3'd1, 8'hF1);
        set_mask(1);
        do_rmw("load1b", OP_LOAD, 3'd1, 8'hA5);
        read_word("rd1_f1b", 3'd1, 8'hF1);
        set_mask(2);
        do_rmw("load1c", OP_LOAD, 3'd1, 8'hA5);
        read_word("rd1_f5", 3'd1, 8'hF5);

        // wr while busy, shift during RMW, wr on the WRITE->IDLE edge
        set_mask(3);
        wr = 1'b1; op = OP_SET; addr = 3'd3;
        step();
        check_eq("bb_busy", busy, 1);
        addr = 3'd4; shift = 1'b1;
        step();
        check_eq("bb_err", err, 1);
        check_eq("bb_mask", mask, 8'h10);
        wr = 1'b0; shift = 1'b0;
        step();
        check_eq("bb_err_off", err, 0);
        check_eq("bb_busy_w", busy, 1);
        wr = 1'b1; addr = 3'd6;
        step();
        wr = 1'b0;
        check_eq("bb_done", done, 1);
        check_eq("bb_err_wr", err, 1);
        check_eq("bb_idle", busy, 0);
        step();
        check_eq("bb_no_capture", busy, 0);
        check_eq("bb_err_off2", err, 0);
        read_word("rd3_08", 3'd3, 8'h08);
        read_word("rd4_00", 3'd4, 8'h00);
        read_word("rd6_00", 3'd6, 8'h00);

        // read on the same edge as the write returns the old value
        set_mask(0);
        wr = 1'b1; op = OP_SET; addr = 3'd7;
        step();
        wr = 1'b0;
        step();
        step();
        rd_en = 1'b1; rd_addr = 3'd7;
        step();
        rd_en = 1'b0;
        check_eq("coll_done", done, 1);
        check_eq("coll_old", rd_data, 8'h00);
        read_word("rd7_01", 3'd7, 8'h01);

        // reset during MODIFY
        set_mask(5);
        wr = 1'b1; op = OP_SET; addr = 3'd0;
        step();
        wr = 1'b0;
        step();
        rst = 1'b0;
        step();
        check_eq("mr_busy", busy, 0);
        check_eq("mr_done", done, 0);
        check_eq("mr_mask", mask, 8'h01);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("mr_no_done", done, 0);
        end
        for (int i = 0; i < 8; i++) begin
            read_word($sformatf("mr_mem%0d", i), 3'(i), 8'h00);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mask_rmw_responder.md
MASK_RMW_RESPONDER -- requirements
Module: mask_rmw_responder

Interface
REQ-001 Parameter WIDTH, default 8, word and mask width in bits.
REQ-002 Parameter DEPTH, default 8, number of memory words; address width is clog2(DEPTH) = 3.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-low.
REQ-005 rst_mask  input  1  one-cycle pulse; reinitialises the mask.
REQ-006 shift  input  1  one-cycle pulse; rotates the mask by one position.
REQ-007 wr  input  1  one-cycle pulse; requests a read-modify-write (RMW).
REQ-008 op  input  2  RMW operation, sampled with wr.
REQ-009 addr  input  3  RMW target word, sampled with wr.
REQ-010 wdata  input  WIDTH  load data for op LOAD, sampled with wr.
REQ-011 rd_en  input  1  read request.
REQ-012 rd_addr  input  3  read address, sampled with rd_en.
REQ-013 rd_data  output  WIDTH  registered read data.
REQ-014 rd_valid  output  1  rd_data valid, one-cycle pulse.
REQ-015 mask  output  WIDTH  live mask register.
REQ-016 busy  output  1  high while an RMW is in progress.
REQ-017 done  output  1  one-cycle pulse on RMW completion.
REQ-018 err  output  1  one-cycle pulse when wr is dropped.

Function
REQ-019 Mask: rst_mask loads 8'h01; shift rotates left, bit7 to bit0; rst_mask has priority over shift in the same cycle.
REQ-020 FSM states IDLE, READ, MODIFY, WRITE; busy = (state != IDLE).
REQ-021 IDLE + wr -> READ; the same edge captures op, addr, wdata and the current mask (mask value before any same-cycle shift or rst_mask).
REQ-022 READ -> MODIFY: tmp <= mem[addr_q].
REQ-023 MODIFY -> WRITE: tmp <= f(tmp), where SET=00 gives tmp|m, CLR=01 gives tmp&~m, TOGGLE=10 gives tmp^m, LOAD=11 gives (wdata&m)|(tmp&~m).
REQ-024 WRITE -> IDLE: mem[addr_q] <= tmp, and done is high for exactly the following cycle.
REQ-025 Latency: wr sampled at edge N -> memory updated at edge N+3 -> done high during cycle N+3..N+4.
REQ-026 wr while busy: no state change and no capture; err is high for the following cycle.
REQ-027 wr in the same cycle that WRITE returns to IDLE is treated as busy: the request is dropped and err pulses.
REQ-028 shift and rst_mask are accepted in every state; they do not alter the captured mask of an RMW in flight.
REQ-029 Read port is independent of the FSM: rd_en at edge N -> rd_data = mem[rd_addr] and rd_valid high during cycle N+1.
REQ-030 A read coinciding with the WRITE edge to the same address returns the pre-write value.
REQ-031 When rd_valid is low, rd_data holds its last value.

Reset
REQ-032 rst low at any edge sets state=IDLE, mask=8'h01, all mem words=0, tmp=0, rd_data=0, rd_valid=0, done=0, err=0.
REQ-033 Reset mid-RMW abandons the operation with no memory write and no done pulse.
REQ-034 Inputs sampled while rst is low are ignored.

Structure
REQ-035 Shared package rmw_pkg holds: the op_t enum (SET, CLR, TOGGLE, LOAD); the state_t enum; the constants WIDTH, DEPTH and MASK_INIT=8'h01.
REQ-036 One sub-module, rmw_mask_reg, holds the rotating mask: inputs clk, rst, rst_mask, shift; output mask.
REQ-037 The memory is a register array, not vendor RAM.

Verification
REQ-038 Reset, then 3 shift pulses -> mask=8'h08; a further rst_mask together with shift -> mask=8'h01.
REQ-039 mask=8'h04, wr op=SET addr=2 -> busy high for 3 cycles, done at N+3; then rd_en addr=2 -> rd_data=8'h04.
REQ-040 mem[5]=8'hFF, mask=8'h81, wr op=CLR -> mem[5]=8'h7E; then op=TOGGLE with the same mask -> mem[5]=8'hFF.
REQ-041 mask=8'h0F, wr op=LOAD wdata=8'hA5 on mem[1]=8'hF0 -> mem[1]=8'hF5.
REQ-042 Second wr one cycle after the first -> err pulse, only the first RMW is applied; shift during the RMW -> the stored result uses the pre-shift mask.
REQ-043 rst low during MODIFY -> mem unchanged (all zeros), done never asserted, busy=0 on the next cycle.
